stack_ctrl_p: RTL and testbench
===============================

STACK_CTRL_P -- requirements
Module: stack_ctrl_p

Interface
REQ-001 Parameter OPW, default 3, opcode width (>=3); bits [2:0] select the operation.
REQ-002 Parameter DEPTH, default 16, stack capacity in entries (>=2).
REQ-003 Parameter SPW, default $clog2(DEPTH+1), stack-pointer width.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low: sampled on the rising edge of clk, effective when 0.
REQ-006 opcode  in  OPW  instruction opcode, stable from ID until return to IF.
REQ-007 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-008 zero  in  1  ToS-is-zero flag, sampled in JZ.
REQ-009 next, jump, PCL, LorD, MR, MW, LR, RegDst, StackSrc, ToS, Push, Pop, LA, LB, Ain, Bin  out  1 each  datapath controls.
REQ-010 ALUop  out  2  ALU operation select.
REQ-011 sp  out  SPW  current stack occupancy.
REQ-012 full / empty  out  1 each  sp==DEPTH / sp==0.
REQ-013 fault  out  1  controller halted on error; fault_code  out  2  01 underflow, 10 overflow, 11 illegal opcode, 00 none.

Function
REQ-014 States SHALL be IF, ID, POP1, SP, ALU, SAVE, PUSH, POP, JUMP, JZ, FAULT.
REQ-015 Decode of opcode[2:0]: 000/001/010 binary ALU, 011 NOT, 100 PUSH, 101 POP, 110 JUMP, 111 JZ; any nonzero opcode[OPW-1:3] is illegal.
REQ-016 Transitions: IF->ID only when mem_ready=1, else hold IF; ID->POP1 (binary ALU or NOT), PUSH, POP, JUMP, JZ or FAULT per REQ-017; POP1->SP (binary) or ALU (NOT); SP->ALU; ALU->SAVE; SAVE->IF; PUSH, POP->IF only when mem_ready=1, else hold; JUMP, JZ->IF; FAULT->FAULT.
REQ-017 ID check, priority illegal > underflow > overflow: binary needs sp>=2; NOT, POP, JZ need sp>=1; PUSH needs sp<DEPTH; JUMP no check; violation -> FAULT with fault_code latched.
REQ-018 All controls default 0; each state drives only those listed here.
REQ-019 IF: MR=1, LorD=1, Ain=1, Bin=0, ALUop=00; next, PCL, LR =mem_ready (PC and IR update exactly once per fetch).
REQ-020 ID: ToS=1, LA=1, RegDst=0.
REQ-021 POP1: Pop=1. SP: Pop=1, ToS=1, RegDst=1, LB=1. ALU: Bin=1, ALUop=opcode[1:0]. SAVE: StackSrc=1, Push=1.
REQ-022 PUSH: MR=1, StackSrc=0, Push=mem_ready. POP: MW=1, Pop=mem_ready.
REQ-023 JUMP: jump=1, PCL=1. JZ: jump=1, PCL=1 if zero=1; else next=1, PCL=1.
REQ-024 sp SHALL increment on any cycle with Push=1, decrement on any cycle with Pop=1; never both in one cycle; net binary op -1, NOT 0.
REQ-025 FAULT: all datapath controls 0, fault=1, sp frozen; exit only via reset.
REQ-026 full/empty combinational from sp; fault_code 00 outside FAULT.

Reset
REQ-027 rst=0 at a rising edge SHALL set state IF, sp=0, fault=0, fault_code=00, overriding any in-progress state including FAULT and mem_ready waits.
REQ-028 Asynchronous rst changes between edges SHALL have no effect.

Verification
REQ-029 Reset, mem_ready=0 for 3 cycles then 1 -> hold IF, PCL/LR=0 while waiting, single PCL/LR/next pulse, then ID; sp=0, empty=1.
REQ-030 PUSH x3, ADD (000), mem_ready=1 -> sp 1,2,3 then 2; ADD path IF,ID,POP1,SP,ALU,SAVE with ALUop=00 in ALU.
REQ-031 DEPTH=2: PUSH, PUSH, PUSH -> third ID enters FAULT, fault_code=10, sp=2, all controls 0 until rst=0.
REQ-032 sp=1, SUB (001) -> FAULT, fault_code=01; sp=0, POP -> FAULT, fault_code=01.
REQ-033 OPW=4, opcode 1100 with sp=0 -> fault_code=11 (illegal beats underflow).
REQ-034 JZ with zero=1 -> jump=1, PCL=1; zero=0 -> next=1, PCL=1; sp unchanged; rst=0 in POP with mem_ready=0 -> next edge IF, sp=0.

Source files
------------

// File: rtl/stack_ctrl_p.sv
// Multi-cycle controller for a stack machine datapath.
// Tracks stack occupancy and halts on underflow, overflow or illegal opcode.
module stack_ctrl_p #(
    parameter int OPW   = 3,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    input  logic           zero,
    output logic           next,
    output logic           jump,
    output logic           PCL,
    output logic           LorD,
    output logic           MR,
    output logic           MW,
    output logic           LR,
    output logic           RegDst,
    output logic           StackSrc,
    output logic           ToS,
    output logic           Push,
    output logic           Pop,
    output logic           LA,
    output logic           LB,
    output logic           Ain,
    output logic           Bin,
    output logic [1:0]     ALUop,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty,
    output logic           fault,
    output logic [1:0]     fault_code
);

    typedef enum logic [3:0] {
        S_IF, S_ID, S_POP1, S_SP, S_ALU, S_SAVE,
        S_PUSH, S_POP, S_JUMP, S_JZ, S_FAULT
    } state_t;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    state_t     state;
    logic [2:0] op;
    logic       illegal;
    logic       need2;
    logic       need1;
    logic [1:0] chk;

    assign op    = opcode[2:0];
    assign full  = (sp == SP_FULL);
    assign empty = (sp == '0);

    if (OPW > 3) begin : g_ext
        assign illegal = |opcode[OPW-1:3];
    end else begin : g_noext
        assign illegal = 1'b0;
    end

    // binary ops consume two operands; NOT, POP and JZ consume one
    assign need2 = ~op[2] & ~(op[1] & op[0]);
    assign need1 = op[0] & (op[1] | op[2]);

    always_comb begin
        chk = 2'b00;
        if (illegal)
            chk = 2'b11;
        else if ((need2 && sp < SPW'(2)) || (need1 && empty))
            chk = 2'b01;
        else if (op == 3'd4 && full)
            chk = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IF;
            sp         <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            if (Push)
                sp <= sp + SPW'(1);
            else if (Pop)
                sp <= sp - SPW'(1);
            unique case (state)
                S_IF:   if (mem_ready) state <= S_ID;
                S_ID: begin
                    if (chk != 2'b00) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_code <= chk;
                    end else begin
                        unique case (op)
                            3'd4:    state <= S_PUSH;
                            3'd5:    state <= S_POP;
                            3'd6:    state <= S_JUMP;
                            3'd7:    state <= S_JZ;
                            default: state <= S_POP1;
                        endcase
                    end
                end
                S_POP1: state <= (op == 3'd3) ? S_ALU : S_SP;
                S_SP:   state <= S_ALU;
                S_ALU:  state <= S_SAVE;
                S_SAVE: state <= S_IF;
                S_PUSH: if (mem_ready) state <= S_IF;
                S_POP:  if (mem_ready) state <= S_IF;
                S_JUMP: state <= S_IF;
                S_JZ:   state <= S_IF;
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    always_comb begin
        {next, jump, PCL, LorD, MR, MW, LR, RegDst} = '0;
        {StackSrc, ToS, Push, Pop, LA, LB, Ain, Bin} = '0;
        ALUop = 2'b00;
        unique case (state)
            S_IF: begin
                MR   = 1'b1;
                LorD = 1'b1;
                Ain  = 1'b1;
                next = mem_ready;
                PCL  = mem_ready;
                LR   = mem_ready;
            end
            S_ID: begin
                ToS = 1'b1;
                LA  = 1'b1;
            end
            S_POP1: Pop = 1'b1;
            S_SP: begin
                Pop    = 1'b1;
                ToS    = 1'b1;
                RegDst = 1'b1;
                LB     = 1'b1;
            end
            S_ALU: begin
                Bin   = 1'b1;
                ALUop = opcode[1:0];
            end
            S_SAVE: begin
                StackSrc = 1'b1;
                Push     = 1'b1;
            end
            S_PUSH: begin
                MR   = 1'b1;
                Push = mem_ready;
            end
            S_POP: begin
                MW  = 1'b1;
                Pop = mem_ready;
            end
            S_JUMP: begin
                jump = 1'b1;
                PCL  = 1'b1;
            end
            S_JZ: begin
                jump = zero;
                next = ~zero;
                PCL  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stack_ctrl_p.sv
// Bench for stack_ctrl_p: a default instance and a DEPTH=2/OPW=4 instance.
// Per-cycle expected controls are queued per instruction and compared each cycle.
module tb_stack_ctrl_p;

    localparam logic [17:0] M_NEXT = 18'd1 << 17;
    localparam logic [17:0] M_JUMP = 18'd1 << 16;
    localparam logic [17:0] M_PCL  = 18'd1 << 15;
    localparam logic [17:0] M_LORD = 18'd1 << 14;
    localparam logic [17:0] M_MR   = 18'd1 << 13;
    localparam logic [17:0] M_MW   = 18'd1 << 12;
    localparam logic [17:0] M_LR   = 18'd1 << 11;
    localparam logic [17:0] M_RD   = 18'd1 << 10;
    localparam logic [17:0] M_SS   = 18'd1 << 9;
    localparam logic [17:0] M_TOS  = 18'd1 << 8;
    localparam logic [17:0] M_PUSH = 18'd1 << 7;
    localparam logic [17:0] M_POP  = 18'd1 << 6;
    localparam logic [17:0] M_LA   = 18'd1 << 5;
    localparam logic [17:0] M_LB   = 18'd1 << 4;
    localparam logic [17:0] M_AIN  = 18'd1 << 3;
    localparam logic [17:0] M_BIN  = 18'd1 << 2;
    localparam logic [17:0] IFW    = M_MR | M_LORD | M_AIN;
    localparam logic [17:0] IFF    = IFW | M_NEXT | M_PCL | M_LR;

    typedef struct {
        int          sel;
        logic        mr;
        logic        zr;
        logic        gl;
        logic [17:0] ctl;
        int          sp;
        logic        flt;
        logic [1:0]  fc;
        string       nm;
    } item_t;

    typedef struct {
        logic [2:0] op;
        logic       zr;
        int         mw;
        logic       gl;
        int         sp_after;
        logic [1:0] fc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       mem_ready;
    logic       zero;
    logic [2:0] op0;
    logic [3:0] op1;

    wire [15:0] c0, c1;
    wire [1:0]  a0, a1, fc0, fc1;
    wire [4:0]  sp0;
    wire [1:0]  sp1;
    wire        f0, e0, fl0, f1, e1, fl1;

    item_t q[$];
    int    msp[2];
    logic  mflt[2];
    logic [1:0] mfc[2];
    int    dep[2] = '{16, 2};
    int    checks = 0;
    int    passes = 0;
    vec_t  tbl[11];

    stack_ctrl_p u0 (
        .clk(clk), .rst(rst), .opcode(op0), .mem_ready(mem_ready), .zero(zero),
        .next(c0[15]), .jump(c0[14]), .PCL(c0[13]), .LorD(c0[12]),
        .MR(c0[11]), .MW(c0[10]), .LR(c0[9]), .RegDst(c0[8]),
        .StackSrc(c0[7]), .ToS(c0[6]), .Push(c0[5]), .Pop(c0[4]),
        .LA(c0[3]), .LB(c0[2]), .Ain(c0[1]), .Bin(c0[0]),
        .ALUop(a0), .sp(sp0), .full(f0), .empty(e0),
        .fault(fl0), .fault_code(fc0)
    );

    stack_ctrl_p #(.OPW(4), .DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .opcode(op1), .mem_ready(mem_ready), .zero(zero),
        .next(c1[15]), .jump(c1[14]), .PCL(c1[13]), .LorD(c1[12]),
        .MR(c1[11]), .MW(c1[10]), .LR(c1[9]), .RegDst(c1[8]),
        .StackSrc(c1[7]), .ToS(c1[6]), .Push(c1[5]), .Pop(c1[4]),
        .LA(c1[3]), .LB(c1[2]), .Ain(c1[1]), .Bin(c1[0]),
        .ALUop(a1), .sp(sp1), .full(f1), .empty(e1),
        .fault(fl1), .fault_code(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void put(int sel, logic mr, logic zr,
                                logic [17:0] ctl, string nm, logic gl);
        item_t it;
        it.sel = sel;
        it.mr  = mr;
        it.zr  = zr;
        it.gl  = gl;
        it.ctl = ctl;
        it.sp  = msp[sel];
        it.flt = mflt[sel];
        it.fc  = mfc[sel];
        it.nm  = nm;
        q.push_back(it);
        if ((ctl & M_PUSH) != 0) msp[sel]++;
        if ((ctl & M_POP) != 0) msp[sel]--;
    endfunction

    task automatic expand(int sel, logic [3:0] op, logic zr,
                          int ifw, int mw, logic gl);
        logic [2:0] c;
        int         need;
        logic [1:0] fc;
        c = op[2:0];
        if (sel == 0) op0 = c; else op1 = op;
        for (int i = 0; i < ifw; i++) put(sel, 1'b0, zr, IFW, "IFWAIT", gl && i == 0);
        put(sel, 1'b1, zr, IFF, "IF", gl && ifw == 0);
        put(sel, 1'b1, zr, M_TOS | M_LA, "ID", 1'b0);
        need = (c < 3'd3) ? 2 : (c[0] ? 1 : 0);
        fc = op[3] ? 2'b11 :
             (msp[sel] < need) ? 2'b01 :
             (c == 3'd4 && msp[sel] == dep[sel]) ? 2'b10 : 2'b00;
        if (fc != 2'b00) begin
            mflt[sel] = 1'b1;
            mfc[sel]  = fc;
            repeat (3) put(sel, 1'b1, zr, '0, "FAULT", 1'b0);
            return;
        end
        case (c)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                put(sel, 1'b1, zr, M_POP, "POP1", 1'b0);
                if (c != 3'd3)
                    put(sel, 1'b1, zr, M_POP | M_TOS | M_RD | M_LB, "SP", 1'b0);
                put(sel, 1'b1, zr, M_BIN | 18'(c[1:0]), "ALU", 1'b0);
                put(sel, 1'b1, zr, M_SS | M_PUSH, "SAVE", 1'b0);
            end
            3'd4: begin
                for (int i = 0; i < mw; i++) put(sel, 1'b0, zr, M_MR, "PUSHW", 1'b0);
                put(sel, 1'b1, zr, M_MR | M_PUSH, "PUSH", 1'b0);
            end
            3'd5: begin
                for (int i = 0; i < mw; i++) put(sel, 1'b0, zr, M_MW, "POPW", 1'b0);
                put(sel, 1'b1, zr, M_MW | M_POP, "POP", 1'b0);
            end
            3'd6: put(sel, 1'b1, zr, M_JUMP | M_PCL, "JUMP", 1'b0);
            default: put(sel, 1'b1, zr, zr ? (M_JUMP | M_PCL) : (M_NEXT | M_PCL), "JZ", 1'b0);
        endcase
    endtask

    task automatic run();
        item_t       it;
        logic [27:0] got;
        logic [27:0] want;
        while (q.size() > 0) begin
            it = q.pop_front();
            mem_ready = it.mr;
            zero      = it.zr;
            if (it.gl) begin
                #1 rst = 1'b0;
                #1 rst = 1'b1;
            end
            @(negedge clk);
            want = {it.ctl, 5'(it.sp), it.sp == dep[it.sel], it.sp == 0, it.flt, it.fc};
            got  = (it.sel == 0) ? {c0, a0, sp0, f0, e0, fl0, fc0}
                                 : {c1, a1, 3'b000, sp1, f1, e1, fl1, fc1};
            checks++;
            if (got === want) passes++;
            else $display("FAIL %s dut%0d: got %h want %h", it.nm, it.sel, got, want);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_end(string nm, int sel, int sp_w, logic [1:0] fc_w);
        int         sp_g;
        logic [1:0] fc_g;
        sp_g = (sel == 0) ? int'(sp0) : int'(sp1);
        fc_g = (sel == 0) ? fc0 : fc1;
        checks++;
        if (sp_g == sp_w && fc_g === fc_w) passes++;
        else $display("FAIL %s: sp=%0d code=%b, want sp=%0d code=%b",
                      nm, sp_g, fc_g, sp_w, fc_w);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        msp  = '{0, 0};
        mflt = '{1'b0, 1'b0};
        mfc  = '{2'b00, 2'b00};
        put(0, 1'b0, 1'b0, IFW, "RST", 1'b0);
        put(1, 1'b0, 1'b0, IFW, "RST", 1'b0);
        run();
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{3'd4, 1'b0, 2, 1'b0, 2, 2'b00};
        tbl[1]  = '{3'd4, 1'b0, 0, 1'b0, 3, 2'b00};
        tbl[2]  = '{3'd0, 1'b0, 0, 1'b0, 2, 2'b00};
        tbl[3]  = '{3'd3, 1'b0, 0, 1'b0, 2, 2'b00};
        tbl[4]  = '{3'd7, 1'b1, 0, 1'b0, 2, 2'b00};
        tbl[5]  = '{3'd7, 1'b0, 0, 1'b1, 2, 2'b00};
        tbl[6]  = '{3'd6, 1'b0, 0, 1'b0, 2, 2'b00};
        tbl[7]  = '{3'd1, 1'b0, 0, 1'b0, 1, 2'b00};
        tbl[8]  = '{3'd5, 1'b0, 1, 1'b0, 0, 2'b00};
        tbl[9]  = '{3'd6, 1'b1, 0, 1'b0, 0, 2'b00};
        tbl[10] = '{3'd5, 1'b0, 0, 1'b0, 0, 2'b01};

        rst = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        op0 = 3'd0;
        op1 = 4'd0;
        do_reset();

        // fetch stalls three cycles before the first instruction
        expand(0, 4'b0100, 1'b0, 3, 0, 1'b0);
        run();
        check_end("first_push", 0, 1, 2'b00);

        foreach (tbl[i]) begin
            expand(0, {1'b0, tbl[i].op}, tbl[i].zr, 0, tbl[i].mw, tbl[i].gl);
            run();
            check_end($sformatf("vec%0d", i), 0, tbl[i].sp_after, tbl[i].fc);
        end

        do_reset();
        expand(0, 4'b0100, 1'b0, 0, 0, 1'b0);
        run();
        expand(0, 4'b0001, 1'b0, 0, 0, 1'b0);
        run();
        check_end("sub_underflow", 0, 1, 2'b01);

        // reset taken while POP waits on memory
        do_reset();
        expand(0, 4'b0100, 1'b0, 0, 0, 1'b0);
        run();
        expand(0, 4'b0100, 1'b0, 0, 0, 1'b0);
        run();
        op0 = 3'd5;
        put(0, 1'b1, 1'b0, IFF, "IF", 1'b0);
        put(0, 1'b1, 1'b0, M_TOS | M_LA, "ID", 1'b0);
        put(0, 1'b0, 1'b0, M_MW, "POPW", 1'b0);
        put(0, 1'b0, 1'b0, M_MW, "POPW", 1'b0);
        run();
        rst = 1'b0;
        put(0, 1'b0, 1'b0, M_MW, "POPRST", 1'b0);
        run();
        msp[0] = 0;
        put(0, 1'b0, 1'b0, IFW, "AFTRST", 1'b0);
        run();
        rst = 1'b1;

        do_reset();
        for (int i = 0; i < 3; i++) begin
            expand(1, 4'b0100, 1'b0, 0, 0, 1'b0);
            run();
        end
        check_end("overflow", 1, 2, 2'b10);

        do_reset();
        expand(1, 4'b1100, 1'b0, 0, 0, 1'b0);
        run();
        check_end("illegal", 1, 0, 2'b11);

        do_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
